debug_host: RTL and testbench

//  Initiator end of the UART debug protocol ('+' + 2-char command [+ 4 addr bytes], reply "OK"[+data] / "NO").

---
 rtl/debug_host.sv | 222 ++++++++++++++++++++++
 tb/tb_debug_host.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_host.sv
// debug_host: initiator side of the UART debug protocol.
//   A request is '+' followed by a two-character command: HL, RE, PC, ST or MR.
//   MR also sends four address bytes, most significant byte first.
//   The reply is "OK" plus any data bytes, or "NO".
//   Bytes go out one at a time through a UART TX engine.
//   The reply is parsed from the bytes delivered by a UART RX engine.
//   The result comes back on a one-cycle rsp_valid strobe.
// Ports:
//   clk, reset          system clock; asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_op, req_addr    operation code (0..4 legal) and MR address
//   rsp_valid           one-cycle completion strobe
//   rsp_status          0=OK 1=NO 2=TIMEOUT 3=BAD
//   rsp_data            PC/MR: 32-bit word, ST: status byte, else 0
//   busy                high whenever a request is in flight
//   tx_start, tx_data   byte transmit request to the TX engine
//   tx_done             TX engine finished the current byte
//   rx_done, rx_data    byte received from the RX engine
module debug_host #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  input  logic        rx_done,
  input  logic [7:0]  rx_data
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_RECV, S_DONE} state_t;

  localparam logic [2:0] OP_HL = 3'd0;
  localparam logic [2:0] OP_RE = 3'd1;
  localparam logic [2:0] OP_PC = 3'd2;
  localparam logic [2:0] OP_ST = 3'd3;
  localparam logic [2:0] OP_MR = 3'd4;

  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_NO  = 2'd1;
  localparam logic [1:0] ST_TMO = 2'd2;
  localparam logic [1:0] ST_BAD = 2'd3;

  state_t      state;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [2:0]  tx_idx;
  logic [2:0]  rx_cnt;
  logic [7:0]  rx_b0, rx_b2, rx_b3, rx_b4;
  logic [31:0] to_cnt;

  logic        rx_en, rx_take, rx_fin;
  logic [1:0]  rx_fin_status;
  logic [31:0] rx_fin_data;

  // Index of the final byte of the request: '+',C1,C2 plus 4 address bytes for MR.
  function automatic logic [2:0] last_idx(input logic [2:0] op);
    return (op == OP_MR) ? 3'd6 : 3'd2;
  endfunction

  // Number of reply bytes that make up a complete OK reply.
  function automatic logic [2:0] exp_len(input logic [2:0] op);
    case (op)
      OP_HL, OP_RE: return 3'd2;
      OP_ST:        return 3'd3;
      default:      return 3'd6;
    endcase
  endfunction

  function automatic logic [7:0] tx_byte(input logic [2:0] op, input logic [31:0] addr,
                                         input logic [2:0] idx);
    logic [7:0] c1, c2;
    case (op)
      OP_HL:   begin c1 = 8'h48; c2 = 8'h4C; end // "HL"
      OP_RE:   begin c1 = 8'h52; c2 = 8'h45; end // "RE"
      OP_PC:   begin c1 = 8'h50; c2 = 8'h43; end // "PC"
      OP_ST:   begin c1 = 8'h53; c2 = 8'h54; end // "ST"
      default: begin c1 = 8'h4D; c2 = 8'h52; end // "MR"
    endcase
    case (idx)
      3'd0:    return 8'h2B;                     // '+'
      3'd1:    return c1;
      3'd2:    return c2;
      3'd3:    return addr[31:24];
      3'd4:    return addr[23:16];
      3'd5:    return addr[15:8];
      default: return addr[7:0];
    endcase
  endfunction

  // Reply parsing. Capture opens as soon as the last request byte is handed
  // to the TX engine, so a fast responder cannot race the final tx_done.
  always_comb begin
    rx_en         = (state == S_RECV) || ((state == S_SEND) && (tx_idx == last_idx(op_q)));
    rx_take       = rx_en && rx_done;
    rx_fin        = 1'b0;
    rx_fin_status = ST_OK;
    rx_fin_data   = 32'h0;
    if (rx_take) begin
      if ((rx_cnt == 3'd1) && ({rx_b0, rx_data} == 16'h4E4F)) begin        // "NO"
        rx_fin        = 1'b1;
        rx_fin_status = ST_NO;
      end else if ((rx_cnt == 3'd1) && ({rx_b0, rx_data} != 16'h4F4B)) begin // not "OK"
        rx_fin        = 1'b1;
        rx_fin_status = ST_BAD;
      end else if ((rx_cnt + 3'd1) == exp_len(op_q)) begin
        rx_fin        = 1'b1;
        rx_fin_status = ST_OK;
        case (op_q)
          OP_PC, OP_MR: rx_fin_data = {rx_b2, rx_b3, rx_b4, rx_data};
          OP_ST:        rx_fin_data = {24'h0, rx_data};
          default:      rx_fin_data = 32'h0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      req_ready  <= 1'b0;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= 2'd0;
      rsp_data   <= 32'h0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h0;
      op_q       <= 3'd0;
      addr_q     <= 32'h0;
      tx_idx     <= 3'd0;
      rx_cnt     <= 3'd0;
      rx_b0      <= 8'h0;
      rx_b2      <= 8'h0;
      rx_b3      <= 8'h0;
      rx_b4      <= 8'h0;
      to_cnt     <= 32'h0;
    end else begin
      tx_start  <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            op_q      <= req_op;
            addr_q    <= req_addr;
            rx_cnt    <= 3'd0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_op > OP_MR) begin
              state      <= S_DONE;
              rsp_valid  <= 1'b1;
              rsp_status <= ST_BAD;
              rsp_data   <= 32'h0;
            end else begin
              state    <= S_SEND;
              tx_idx   <= 3'd0;
              tx_start <= 1'b1;
              tx_data  <= 8'h2B;
            end
          end
        end
        S_SEND: begin
          if (tx_done) begin
            if (tx_idx == last_idx(op_q)) begin
              state  <= S_RECV;
              to_cnt <= 32'h0;
            end else begin
              tx_idx   <= tx_idx + 3'd1;
              tx_start <= 1'b1;
              tx_data  <= tx_byte(op_q, addr_q, tx_idx + 3'd1);
            end
          end
        end
        S_RECV: begin
          // A byte arriving on the expiry cycle still counts.
          if (rx_take) begin
            to_cnt <= 32'h0;
          end else if (to_cnt == TIMEOUT_CYCLES - 32'd1) begin
            state      <= S_DONE;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_TMO;
            rsp_data   <= 32'h0;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      if (rx_take) begin
        case (rx_cnt)
          3'd0:    rx_b0 <= rx_data;
          3'd2:    rx_b2 <= rx_data;
          3'd3:    rx_b3 <= rx_data;
          3'd4:    rx_b4 <= rx_data;
          default: ;
        endcase
        rx_cnt <= rx_cnt + 3'd1;
        if (rx_fin) begin
          state      <= S_DONE;
          rsp_valid  <= 1'b1;
          rsp_status <= rx_fin_status;
          rsp_data   <= rx_fin_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_debug_host.sv
// tb_debug_host: self-checking bench for debug_host (TIMEOUT_CYCLES=100).
// The bench plays the role of the TX and RX engines.
// A transaction-level model predicts each reply's status, data and the cycle
// on which rsp_valid must appear. That prediction uses deadline arithmetic on
// byte arrival times.
module tb_debug_host;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_data;
  logic        busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h0;

  debug_host #(.TIMEOUT_CYCLES(32'd100)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_data(rsp_data), .busy(busy),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .rx_done(rx_done), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit chk_ready = 1'b0;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] d;
    int          c;
  } exp_t;
  exp_t exp_q[$];

  // Reply schedule for the next transaction: byte values and arrival
  // offsets in cycles relative to the first cycle after the last tx_done.
  logic [7:0] rep_b[8];
  int         rep_t[8];
  int         rep_n = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic logic [7:0] tx_byte_ref(input logic [2:0] op, input logic [31:0] a,
                                             input int i);
    string names;
    names = "HLREPCSTMR";
    if (i == 0) return 8'h2B;
    if (i < 3) return names[op * 2 + i - 1];
    return a[31 - 8 * (i - 3) -: 8];
  endfunction

  // Expected outcome of one transaction. off is the rsp_valid cycle relative
  // to RECV entry (or to the accept cycle for an illegal op).
  function automatic void model(input logic [2:0] op, output logic [1:0] st,
                                output logic [31:0] d, output int off);
    int explen, lc, n;
    logic [7:0] g[6];
    st = 2'd2; d = 32'h0; lc = 0; n = 0; off = TMO;
    if (op > 3'd4) begin
      st = 2'd3; off = 1;
      return;
    end
    explen = (op < 3'd2) ? 2 : (op == 3'd3) ? 3 : 6;
    for (int i = 0; i < rep_n; i++) begin
      // The idle count restarts one cycle after each byte; a byte on the
      // last allowed cycle still beats the timeout.
      if (rep_t[i] > lc + TMO - 1) break;
      g[n] = rep_b[i];
      n++;
      lc = rep_t[i] + 1;
      if (n == 2 && g[0] == "N" && g[1] == "O") begin st = 2'd1; off = lc; return; end
      if (n == 2 && !(g[0] == "O" && g[1] == "K")) begin st = 2'd3; off = lc; return; end
      if (n == explen) begin
        st = 2'd0; off = lc;
        if (explen == 6) d = {g[2], g[3], g[4], g[5]};
        else if (explen == 3) d = {24'h0, g[2]};
        return;
      end
    end
    off = lc + TMO;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every rsp_valid must match the oldest prediction.
  always @(negedge clk) begin
    if (reset) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_status", 32'(rsp_status), 32'(e.st));
          check("rsp_data", rsp_data, e.d);
          check("rsp_cycle", cyc, e.c);
        end
      end
      if (chk_ready) check("ready_xor_busy", 32'(req_ready ^ busy), 32'd1);
      check("tx_start_while_idle", 32'(tx_start & ~busy), 32'd0);
    end
  end

  task automatic do_reset();
    chk_ready = 1'b0;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_ctrl", {28'h0, req_ready, rsp_valid, busy, tx_start}, 32'h0);
      check("rst_status", 32'(rsp_status), 32'h0);
      check("rst_rsp_data", rsp_data, 32'h0);
      check("rst_tx_data", 32'(tx_data), 32'h0);
      step();
    end
    reset = 1'b1;
    step();
    step();
    check("ready_after_reset", 32'(req_ready), 32'd1);
    check("no_pending_rsp", exp_q.size(), 0);
    chk_ready = 1'b1;
  endtask

  task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input int abort_after,
                         input bit pin, input logic [1:0] pst, input logic [31:0] pd,
                         input int poff);
    int w, a, n, last_done, e, d, off;
    logic [1:0]  st;
    logic [31:0] dat;
    logic [7:0]  cap;
    exp_t x;
    model(op, st, dat, off);
    if (pin) begin
      check("model_pin_status", 32'(st), 32'(pst));
      check("model_pin_data", dat, pd);
      if (poff >= 0) check("model_pin_off", off, poff);
    end
    w = 0;
    while (!req_ready && w < 50) begin step(); w++; end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr;
    a = cyc;
    step();
    req_valid = 1'b0; req_op = 3'($urandom); req_addr = $urandom;
    if (op > 3'd4) begin
      x.st = st; x.d = dat; x.c = a + off;
      exp_q.push_back(x);
      check("illegal_no_tx", 32'(tx_start), 32'd0);
    end else begin
      n = (op == 3'd4) ? 7 : 3;
      last_done = cyc;
      for (int i = 0; i < n; i++) begin
        w = 0;
        while (!tx_start && w < 8) begin step(); w++; end
        check("tx_start_seen", 32'(tx_start), 32'd1);
        check("tx_byte", 32'(tx_data), 32'(tx_byte_ref(op, addr, i)));
        cap = tx_data;
        d = $urandom_range(1, 4);
        for (int k = 0; k < d; k++) begin
          step();
          check("tx_hold", {23'h0, tx_start, tx_data}, {23'h0, 1'b0, cap});
        end
        tx_done = 1'b1;
        last_done = cyc;
        step();
        tx_done = 1'b0;
        if (abort_after == i + 1) begin
          do_reset();
          return;
        end
      end
      e = last_done + 1;
      x.st = st; x.d = dat; x.c = e + off;
      exp_q.push_back(x);
      for (int i = 0; i < rep_n; i++) begin
        while (cyc < e + rep_t[i]) step();
        rx_done = 1'b1; rx_data = rep_b[i];
        step();
        rx_done = 1'b0; rx_data = 8'($urandom);
      end
    end
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin step(); w++; end
    check("rsp_arrived", exp_q.size(), 0);
    exp_q.delete();
    step();
    step();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, explen, kind, tt;
    logic [2:0] op;
    logic [7:0] lit[7];
    lit = '{8'h2B, 8'h4D, 8'h52, 8'h00, 8'h00, 8'h10, 8'h04};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl_init", {28'h0, req_ready, rsp_valid, busy, tx_start}, 32'h0);
    check("rst_data_init", rsp_data, 32'h0);
    check("rst_tx_data_init", 32'(tx_data), 32'h0);
    reset = 1'b1;
    step();
    step();
    check("ready_after_init", 32'(req_ready), 32'd1);
    chk_ready = 1'b1;

    // HL with OK reply
    rep_n = 2; rep_b[0] = "O"; rep_b[1] = "K"; rep_t[0] = 2; rep_t[1] = 4;
    run_req(3'd0, 32'h0, 0, 1'b1, 2'd0, 32'h0, 5);

    // MR to 0x1004 returning DEADBEEF
    for (int i = 0; i < 7; i++) check("pin_tx_ref", 32'(tx_byte_ref(3'd4, 32'h0000_1004, i)), 32'(lit[i]));
    rep_n = 6;
    rep_b[0] = "O"; rep_b[1] = "K"; rep_b[2] = 8'hDE; rep_b[3] = 8'hAD; rep_b[4] = 8'hBE; rep_b[5] = 8'hEF;
    for (int i = 0; i < 6; i++) rep_t[i] = i + 1;
    run_req(3'd4, 32'h0000_1004, 0, 1'b1, 2'd0, 32'hDEAD_BEEF, 7);

    // PC answered NO, followed by a stray byte
    rep_n = 3; rep_b[0] = "N"; rep_b[1] = "O"; rep_b[2] = 8'h33;
    rep_t[0] = 3; rep_t[1] = 5; rep_t[2] = 9;
    run_req(3'd2, 32'h0, 0, 1'b1, 2'd1, 32'h0, 6);

    // ST with no reply; then ST with a single 'O' at cycle 60 (count
    // restarts at 61, so rsp_valid lands at 61 + 100)
    rep_n = 0;
    run_req(3'd3, 32'h0, 0, 1'b1, 2'd2, 32'h0, 100);
    rep_n = 1; rep_b[0] = "O"; rep_t[0] = 60;
    run_req(3'd3, 32'h0, 0, 1'b1, 2'd2, 32'h0, 161);

    // illegal op, then HL answered with garbage
    rep_n = 0;
    run_req(3'd6, 32'h0, 0, 1'b1, 2'd3, 32'h0, 1);
    rep_n = 2; rep_b[0] = "X"; rep_b[1] = "Y"; rep_t[0] = 1; rep_t[1] = 2;
    run_req(3'd0, 32'h0, 0, 1'b1, 2'd3, 32'h0, 3);

    // reset in the middle of an MR, then a fresh ST
    rep_n = 0;
    run_req(3'd4, 32'hCAFE_0001, 2, 1'b0, 2'd0, 32'h0, -1);
    rep_n = 3; rep_b[0] = "O"; rep_b[1] = "K"; rep_b[2] = "H";
    rep_t[0] = 0; rep_t[1] = 1; rep_t[2] = 2;
    run_req(3'd3, 32'h0, 0, 1'b1, 2'd0, 32'h48, 3);

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      op = (r < 8) ? 3'(r % 5) : 3'($urandom_range(5, 7));
      explen = (op < 3'd2) ? 2 : (op == 3'd3) ? 3 : 6;
      kind = $urandom_range(0, 5);
      rep_n = (kind == 5) ? $urandom_range(0, explen - 1) : explen + $urandom_range(0, 1);
      tt = $urandom_range(0, 15);
      for (int i = 0; i < rep_n; i++) begin
        rep_b[i] = 8'($urandom);
        rep_t[i] = tt;
        tt += ($urandom_range(0, 9) == 0) ? $urandom_range(95, 105) : $urandom_range(1, 12);
      end
      if (kind <= 2 || kind == 5) begin
        if (rep_n > 0) rep_b[0] = "O";
        if (rep_n > 1) rep_b[1] = "K";
      end else if (kind == 3) begin
        rep_b[0] = "N";
        rep_b[1] = "O";
      end
      run_req(op, $urandom, 0, 1'b0, 2'd0, 32'h0, -1);
    end

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
